tx_uart: RTL and testbench
==========================

# tx_uart

UART transmitter for the serial link: accepts a byte over a ready/valid-style handshake and serialises it on `tx_o` as a 10-bit frame. Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity. A one-byte holding register lets the next byte queue during a frame, so frames go out back to back with no idle gap. Bit timing matches the existing UART receive path.

## Interface
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s. `CLKS_PER_BIT = CLK_FREQ/BAUD` (integer division); must be ≥ 2.
- `clk_i`  input  1  single clock; all logic on rising edge.
- `rst_i`  input  1  synchronous, active-high reset.
- `dato_i`  input  8  byte to send; sampled only on an accepting edge.
- `enviar_i`  input  1  send request; accepted on an edge where `enviar_i=1` and `listo_o=1`.
- `tx_o`  output  1  serial line, registered; idles at 1.
- `listo_o`  output  1  holding register empty, new byte can be accepted.
- `ocupado_o`  output  1  frame in progress or byte pending.
- `dato_enviado_o`  output  1  one-cycle pulse at completion of a frame.

## Operation
- Reset values: `tx_o=1`, `listo_o=1`, `ocupado_o=0`, `dato_enviado_o=0`; FSM in IDLE; holding register and counters cleared.
- Holding register (`hold_dato`, `hold_lleno`):
  - On an accepting edge, `dato_i` is written and `hold_lleno` is set.
  - `listo_o = !hold_lleno`.
  - `enviar_i` while `listo_o=0` is ignored: no state change, byte dropped.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx_o=1`. If `hold_lleno`: load shift register from `hold_dato`, clear `hold_lleno`, go to START.
  - START: `tx_o=0` for `CLKS_PER_BIT` cycles, then go to DATA with `bit_idx=0`.
  - DATA: `tx_o=shift[0]` for `CLKS_PER_BIT` cycles per bit, shift right each bit. After bit 7 (`bit_idx==7`), go to STOP.
  - STOP: `tx_o=1` for `CLKS_PER_BIT` cycles. On the last cycle, `dato_enviado_o=1`. Then:
    - if `hold_lleno`: load the next byte, clear `hold_lleno`, go directly to START;
    - else go to IDLE.
- Baud counter:
  - Width `$clog2(CLKS_PER_BIT)`. Cleared on every state entry.
  - Increments each cycle; a bit period ends when count reaches `CLKS_PER_BIT-1`.
  - No free-running tick, so every bit is exactly `CLKS_PER_BIT` cycles.
- `ocupado_o = (state != IDLE) | hold_lleno`, registered.
- Simultaneous events: an accept and a holding→shift transfer cannot occur on the same edge, because the transfer only happens while `listo_o=0`.
- Changes on `dato_i` after acceptance do not affect the frame.
- Reset mid-frame: on the next edge `tx_o=1`, FSM goes to IDLE, the pending byte is discarded, and no `dato_enviado_o` pulse is produced.

## Timing
- Acceptance at edge E0:
  - `listo_o` low after E0.
  - FSM transfers at E1: `tx_o` low after E1 and `listo_o` high again after E1.
  - A second byte can be accepted at E2 or later.
- Frame length: `10*CLKS_PER_BIT` cycles from the start-bit falling edge to the end of the stop bit.
- `dato_enviado_o` is high during the last stop-bit cycle.
- Back-to-back frames: the next start bit begins the cycle immediately after the stop bit ends (0 idle cycles).
- Throughput: one byte per `10*CLKS_PER_BIT` cycles.

## Structure
- Shared header `uart_defs.vh`:
  - FSM state encodings (IDLE/START/DATA/STOP);
  - frame constants (`DATA_BITS=8`, `STOP_LEVEL=1'b1`, `IDLE_LEVEL=1'b1`).
  - The receive path uses the same constants.
- One sub-module, `cont_baud`: clearable counter parameterised by `CLKS_PER_BIT`; outputs `fin_bit` on count `CLKS_PER_BIT-1`.
- Top level holds the FSM, shift register, bit index and holding register.

## Test plan
All scenarios use `CLK_FREQ=16`, `BAUD=1` (16 cycles/bit).
- **Reset:** hold `rst_i` 3 cycles → `tx_o=1`, `listo_o=1`, `ocupado_o=0`, `dato_enviado_o=0`.
- **Single byte:** send 0x55 at E0 → `tx_o` after E1 is 0,1,0,1,0,1,0,1,0,1, each bit 16 cycles. `dato_enviado_o` pulses once at cycle E1+160, then the FSM returns to IDLE.
- **Back-to-back:** send 0xA3, then 0x0F while frame 1 is in DATA → the second start bit follows the stop bit with 0 idle cycles. `tx_o` bits LSB first. Two `dato_enviado_o` pulses, 160 cycles apart.
- **Overflow:** with a frame in progress and the holding register full, pulse `enviar_i` with 0xFF → ignored; only the two queued bytes appear on `tx_o`.
- **Reset mid-frame:** assert `rst_i` during data bit 4 of 0x81 with a byte pending → `tx_o=1` after the next edge. No `dato_enviado_o` pulse, `listo_o=1`, and the pending byte is never sent.
- **Loopback:** connect `tx_o` to `rx_uart` with the same parameters and send 0x00, 0xFF, 0x3C → `rx_uart` reports the same three bytes with `dato_listo_o` asserted.

Source files
------------

// File: rtl/tx_uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding and frame line levels.
// The receive path uses the same constants so both ends agree on the frame.
package tx_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int   DATA_BITS   = 8;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/tx_uart_cont_baud.sv
// Clearable bit-period counter; fin_bit marks the last cycle of a bit period.
module tx_uart_cont_baud #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    output logic fin_bit
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign fin_bit = (cnt == CW'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/tx_uart.sv
// UART transmitter: 8N1 frames with a one-byte holding register so frames
// can be issued back to back without an idle gap.
module tx_uart
    import tx_uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] dato_i,
    input  logic       enviar_i,
    output logic       tx_o,
    output logic       listo_o,
    output logic       ocupado_o,
    output logic       dato_enviado_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int BIT_W        = $clog2(DATA_BITS);

    tx_state_t            state, state_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic [BIT_W-1:0]     bit_idx, bit_idx_next;
    logic [DATA_BITS-1:0] hold_dato;
    logic                 hold_lleno, hold_lleno_next;
    logic                 accept, load, tx_next;
    logic                 fin_bit, baud_clr;

    // Counter sits at zero in IDLE and restarts at each bit boundary, so every
    // state entry begins a fresh, exact bit period.
    assign baud_clr = (state == ST_IDLE) | fin_bit;

    tx_uart_cont_baud #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_cont_baud (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr    (baud_clr),
        .fin_bit(fin_bit)
    );

    assign accept         = enviar_i & ~hold_lleno;
    assign listo_o        = ~hold_lleno;
    assign dato_enviado_o = (state == ST_STOP) & fin_bit & ~rst_i;

    always_comb begin
        state_next      = state;
        shift_next      = shift;
        bit_idx_next    = bit_idx;
        load            = 1'b0;
        tx_next         = IDLE_LEVEL;

        case (state)
            ST_IDLE: begin
                if (hold_lleno) begin
                    load       = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (fin_bit) begin
                    state_next   = ST_DATA;
                    bit_idx_next = '0;
                end
            end
            ST_DATA: begin
                if (fin_bit) begin
                    if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
                        state_next = ST_STOP;
                    end else begin
                        shift_next   = shift >> 1;
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (fin_bit) begin
                    if (hold_lleno) begin
                        load       = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (load) begin
            shift_next = hold_dato;
        end

        // Accept and transfer are mutually exclusive: transfer needs a full holder.
        hold_lleno_next = accept ? 1'b1 : (load ? 1'b0 : hold_lleno);

        case (state_next)
            ST_START: tx_next = START_LEVEL;
            ST_DATA:  tx_next = shift_next[0];
            ST_STOP:  tx_next = STOP_LEVEL;
            default:  tx_next = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            shift      <= '0;
            bit_idx    <= '0;
            hold_dato  <= '0;
            hold_lleno <= 1'b0;
            tx_o       <= IDLE_LEVEL;
            ocupado_o  <= 1'b0;
        end else begin
            state      <= state_next;
            shift      <= shift_next;
            bit_idx    <= bit_idx_next;
            hold_lleno <= hold_lleno_next;
            tx_o       <= tx_next;
            ocupado_o  <= (state_next != ST_IDLE) | hold_lleno_next;
            if (accept) begin
                hold_dato <= dato_i;
            end
        end
    end

endmodule

// File: tb/tb_tx_uart.sv
// Directed bench for tx_uart at 16 clocks per bit with hand-derived frames.
module tb_tx_uart;

    logic       clk;
    logic       rst_i;
    logic [7:0] dato_i;
    logic       enviar_i;
    logic       tx_o;
    logic       listo_o;
    logic       ocupado_o;
    logic       dato_enviado_o;

    int checks   = 0;
    int failures = 0;

    tx_uart #(
        .CLK_FREQ(16),
        .BAUD    (1)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .dato_i        (dato_i),
        .enviar_i      (enviar_i),
        .tx_o          (tx_o),
        .listo_o       (listo_o),
        .ocupado_o     (ocupado_o),
        .dato_enviado_o(dato_enviado_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered one sample after the start-bit edge; leaves one sample after the
    // edge that ends the stop bit. Optional sends are issued at cycles p1k/p2k.
    task automatic check_frame(input logic [7:0] b, input int p1k, input logic [7:0] p1b,
                               input int p2k, input logic [7:0] p2b, input string nm);
        logic [9:0] fr;
        logic       exp_tx;
        logic       exp_done;
        fr = {1'b1, b, 1'b0};
        for (int k = 0; k < 160; k++) begin
            exp_tx   = fr[k / 16];
            exp_done = (k == 159);
            checks++;
            if (tx_o !== exp_tx) begin
                failures++;
                $display("FAIL %s tx cycle %0d: got %b expected %b", nm, k, tx_o, exp_tx);
            end
            checks++;
            if (dato_enviado_o !== exp_done) begin
                failures++;
                $display("FAIL %s done cycle %0d: got %b expected %b", nm, k, dato_enviado_o, exp_done);
            end
            enviar_i = (k == p1k) || (k == p2k);
            dato_i   = (k == p2k) ? p2b : p1b;
            tick();
            enviar_i = 1'b0;
        end
    endtask

    task automatic check_idle(input string nm);
        checks++;
        if (tx_o !== 1'b1 || ocupado_o !== 1'b0 || listo_o !== 1'b1 || dato_enviado_o !== 1'b0) begin
            failures++;
            $display("FAIL %s idle: got tx=%b ocupado=%b listo=%b done=%b expected 1 0 1 0",
                     nm, tx_o, ocupado_o, listo_o, dato_enviado_o);
        end
    endtask

    task automatic test_reset();
        rst_i    = 1'b1;
        enviar_i = 1'b0;
        dato_i   = 8'h00;
        repeat (3) tick();
        checks++;
        if (tx_o !== 1'b1) begin failures++; $display("FAIL reset tx: got %b expected 1", tx_o); end
        checks++;
        if (listo_o !== 1'b1) begin failures++; $display("FAIL reset listo: got %b expected 1", listo_o); end
        checks++;
        if (ocupado_o !== 1'b0) begin failures++; $display("FAIL reset ocupado: got %b expected 0", ocupado_o); end
        checks++;
        if (dato_enviado_o !== 1'b0) begin failures++; $display("FAIL reset done: got %b expected 0", dato_enviado_o); end
        rst_i = 1'b0;
        tick();
        check_idle("post_reset");
    endtask

    task automatic test_single_byte();
        dato_i   = 8'h55;
        enviar_i = 1'b1;
        tick();
        enviar_i = 1'b0;
        dato_i   = 8'h00;
        checks++;
        if (listo_o !== 1'b0 || ocupado_o !== 1'b1 || tx_o !== 1'b1) begin
            failures++;
            $display("FAIL single after_E0: got listo=%b ocupado=%b tx=%b expected 0 1 1", listo_o, ocupado_o, tx_o);
        end
        tick();
        checks++;
        if (listo_o !== 1'b1) begin failures++; $display("FAIL single listo_E1: got %b expected 1", listo_o); end
        check_frame(8'h55, -1, 8'h00, -1, 8'h00, "single");
        check_idle("single_end");
    endtask

    task automatic test_back_to_back();
        dato_i   = 8'hA3;
        enviar_i = 1'b1;
        tick();
        enviar_i = 1'b0;
        tick();
        check_frame(8'hA3, 50, 8'h0F, -1, 8'h00, "b2b_first");
        check_frame(8'h0F, -1, 8'h00, -1, 8'h00, "b2b_second");
        check_idle("b2b_end");
    endtask

    task automatic test_overflow();
        dato_i   = 8'h12;
        enviar_i = 1'b1;
        tick();
        enviar_i = 1'b0;
        tick();
        check_frame(8'h12, 20, 8'h34, 40, 8'hFF, "ovf_first");
        check_frame(8'h34, -1, 8'h00, -1, 8'h00, "ovf_second");
        check_idle("ovf_end");
    endtask

    task automatic test_reset_mid_frame();
        int saw_low;
        int saw_done;
        dato_i   = 8'h81;
        enviar_i = 1'b1;
        tick();
        enviar_i = 1'b0;
        tick();
        // data bit 4 is cycles 80..95 after the start edge
        for (int k = 0; k < 88; k++) begin
            enviar_i = (k == 20);
            dato_i   = 8'h99;
            tick();
            enviar_i = 1'b0;
        end
        checks++;
        if (tx_o !== 1'b0 || listo_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid pre: got tx=%b listo=%b expected 0 0", tx_o, listo_o);
        end
        rst_i = 1'b1;
        tick();
        checks++;
        if (tx_o !== 1'b1 || listo_o !== 1'b1 || ocupado_o !== 1'b0 || dato_enviado_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid after: got tx=%b listo=%b ocupado=%b done=%b expected 1 1 0 0",
                     tx_o, listo_o, ocupado_o, dato_enviado_o);
        end
        rst_i    = 1'b0;
        saw_low  = 0;
        saw_done = 0;
        for (int k = 0; k < 400; k++) begin
            if (tx_o !== 1'b1) saw_low++;
            if (dato_enviado_o !== 1'b0) saw_done++;
            tick();
        end
        checks++;
        if (saw_low != 0) begin failures++; $display("FAIL rst_mid line_quiet: got %0d active cycles expected 0", saw_low); end
        checks++;
        if (saw_done != 0) begin failures++; $display("FAIL rst_mid no_done: got %0d pulses expected 0", saw_done); end
        check_idle("rst_mid_end");
    endtask

    // Independent line decoder: finds the start bit, samples each bit mid-period.
    task automatic rx_frame(input logic do_push, input logic [7:0] push_b,
                            output logic [7:0] got, output logic found, output logic framing_ok);
        found      = 1'b0;
        framing_ok = 1'b0;
        got        = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if (tx_o === 1'b0) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        if (found) begin
            enviar_i = do_push;
            dato_i   = push_b;
            tick();
            enviar_i = 1'b0;
            repeat (7) tick();
            framing_ok = (tx_o === 1'b0);
            for (int j = 0; j < 8; j++) begin
                repeat (16) tick();
                got[j] = tx_o;
            end
            repeat (16) tick();
            framing_ok = framing_ok && (tx_o === 1'b1);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] exp_b [3];
        logic [7:0] got;
        logic       found;
        logic       fr_ok;
        exp_b[0] = 8'h00;
        exp_b[1] = 8'hFF;
        exp_b[2] = 8'h3C;
        dato_i   = exp_b[0];
        enviar_i = 1'b1;
        tick();
        enviar_i = 1'b0;
        tick();
        for (int n = 0; n < 3; n++) begin
            rx_frame(n < 2, (n < 2) ? exp_b[n + 1] : 8'h00, got, found, fr_ok);
            checks++;
            if (!found || !fr_ok || got !== exp_b[n]) begin
                failures++;
                $display("FAIL loopback byte%0d: got %h (found=%b framing=%b) expected %h",
                         n, got, found, fr_ok, exp_b[n]);
            end
        end
        repeat (10) tick();
        check_idle("loopback_end");
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
